// File: rtl/nor_half_adder_pkg.sv
// Shared types for the NOR-only half-adder cell: the per-lane result pair
// carried through the registered stage.
package nor_half_adder_pkg;

    typedef struct packed {
        logic sum;
        logic carry;
    } ha_res_t;

    localparam ha_res_t HA_RES_RESET = '{sum: 1'b0, carry: 1'b0};

endpackage

// File: rtl/nor_half_adder_nor2_cell.sv
// Single 2-input NOR, kept as its own cell so a library gate can be swapped in.
// Zero latency, purely combinational; no flow control.
module nor2_cell (
    input  logic a_i,
    input  logic b_i,
    output logic y_o
);

    assign y_o = ~(a_i | b_i);

endmodule

// File: rtl/nor_half_adder.sv
// Per-lane half adder built only from 2-input NOR cells, plus a registered copy.
// sum/carry are combinational; sum_q/carry_q lag by one clk; no backpressure.
module nor_half_adder
    import nor_half_adder_pkg::*;
#(
    parameter int WIDTH = 1
) (
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] sum_q,
    output logic [WIDTH-1:0] carry_q
);

    ha_res_t [WIDTH-1:0] res_d;
    ha_res_t [WIDTH-1:0] res_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        logic n1, n2, n3, xn, na, nb;

        // Sum: XNOR from four NORs, then a NOR used as an inverter.
        nor2_cell u_n1  (.a_i(a[i]), .b_i(b[i]), .y_o(n1));
        nor2_cell u_n2  (.a_i(a[i]), .b_i(n1),   .y_o(n2));
        nor2_cell u_n3  (.a_i(b[i]), .b_i(n1),   .y_o(n3));
        nor2_cell u_xn  (.a_i(n2),   .b_i(n3),   .y_o(xn));
        nor2_cell u_sum (.a_i(xn),   .b_i(xn),   .y_o(sum[i]));

        // Carry: AND as NOR of the two inverted inputs.
        nor2_cell u_na  (.a_i(a[i]), .b_i(a[i]), .y_o(na));
        nor2_cell u_nb  (.a_i(b[i]), .b_i(b[i]), .y_o(nb));
        nor2_cell u_cy  (.a_i(na),   .b_i(nb),   .y_o(carry[i]));

        assign res_d[i].sum   = sum[i];
        assign res_d[i].carry = carry[i];
        assign sum_q[i]       = res_q[i].sum;
        assign carry_q[i]     = res_q[i].carry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= {WIDTH{HA_RES_RESET}};
        end else begin
            res_q <= res_d;
        end
    end

endmodule

// File: tb/tb_nor_half_adder.sv
// Bench for nor_half_adder: directed edge cases, random lanes, full-adder composition.
module tb_nor_half_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // single-lane instance
    logic       a1 = 1'b0, b1 = 1'b0;
    logic       s1, c1, s1_q, c1_q;
    // four-lane instance
    logic [3:0] a4 = '0, b4 = '0;
    logic [3:0] s4, c4, s4_q, c4_q;
    // full adder from two instances
    logic       fa_a = 1'b0, fa_b = 1'b0, fa_cin = 1'b0;
    logic       h1_s, h1_c, h1_sq, h1_cq, h2_s, h2_c, h2_sq, h2_cq;
    logic       fa_cout;

    nor_half_adder #(.WIDTH(1)) u_dut1 (
        .sum(s1), .carry(c1), .a(a1), .b(b1), .clk(clk), .rst_n(rst_n),
        .sum_q(s1_q), .carry_q(c1_q));

    nor_half_adder #(.WIDTH(4)) u_dut4 (
        .sum(s4), .carry(c4), .a(a4), .b(b4), .clk(clk), .rst_n(rst_n),
        .sum_q(s4_q), .carry_q(c4_q));

    nor_half_adder #(.WIDTH(1)) u_fa_h1 (
        .sum(h1_s), .carry(h1_c), .a(fa_a), .b(fa_b), .clk(clk), .rst_n(rst_n),
        .sum_q(h1_sq), .carry_q(h1_cq));

    nor_half_adder #(.WIDTH(1)) u_fa_h2 (
        .sum(h2_s), .carry(h2_c), .a(h1_s), .b(fa_cin), .clk(clk), .rst_n(rst_n),
        .sum_q(h2_sq), .carry_q(h2_cq));

    // OR of the two carries: NOR followed by a NOR inverter
    logic fa_nor;
    assign fa_nor  = ~(h1_c | h2_c);
    assign fa_cout = ~(fa_nor | fa_nor);

    int n_checks = 0;
    int n_fails  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: each lane is an independent 1-bit addition; result = {carry, sum}.
    function automatic logic [7:0] ha_model(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] s, c;
        for (int i = 0; i < 4; i++) begin
            int t;
            t    = int'(a[i]) + int'(b[i]);
            s[i] = (t % 2) == 1;
            c[i] = (t / 2) == 1;
        end
        return {c, s};
    endfunction

    logic [1:0] exh_sum [4] = '{2'd0, 2'd1, 2'd1, 2'd0};
    logic [1:0] exh_cy  [4] = '{2'd0, 2'd0, 2'd0, 2'd1};

    initial begin
        logic [7:0] exp4;
        logic [7:0] exp1;
        logic [3:0] ab;

        // reset state
        #1;
        chk("rst_s1_q", 32'(s1_q), 0);
        chk("rst_c1_q", 32'(c1_q), 0);
        chk("rst_s4_q", 32'(s4_q), 0);
        chk("rst_c4_q", 32'(c4_q), 0);

        // exhaustive single lane, while reset is held (combinational unaffected)
        for (int k = 0; k < 4; k++) begin
            ab = 4'(k);
            a1 = ab[1];
            b1 = ab[0];
            #1;
            chk($sformatf("exh_sum_%0d", k), 32'(s1), 32'(exh_sum[k]));
            chk($sformatf("exh_cy_%0d", k),  32'(c1), 32'(exh_cy[k]));
        end
        chk("exh_regs_in_reset", 32'({s1_q, c1_q}), 0);

        // registered latency
        @(negedge clk);
        rst_n = 1'b1;
        a1 = 1'b1; b1 = 1'b1;
        #1;
        chk("lat_cq_before", 32'(c1_q), 0);
        @(posedge clk); #1;
        chk("lat_cq_after", 32'(c1_q), 1);
        chk("lat_sq_after", 32'(s1_q), 0);
        @(negedge clk);
        a1 = 1'b0; b1 = 1'b1;
        #1;
        chk("lat_sq_before2", 32'(s1_q), 0);
        @(posedge clk); #1;
        chk("lat_sq_after2", 32'(s1_q), 1);
        chk("lat_cq_after2", 32'(c1_q), 0);

        // async reset between edges
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst_sq_now", 32'(s1_q), 0);
        chk("arst_cq_now", 32'(c1_q), 0);
        repeat (2) begin
            @(posedge clk); #1;
            chk("arst_sq_hold", 32'(s1_q), 0);
        end

        // reset coinciding with a rising edge
        @(negedge clk);
        rst_n = 1'b1;
        a1 = 1'b1; b1 = 1'b1;
        @(posedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_edge_cq", 32'(c1_q), 0);
        // first edge after release loads current values
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("release_cq", 32'(c1_q), 1);

        // multi-lane directed
        @(negedge clk);
        a4 = 4'b1100; b4 = 4'b1010;
        #1;
        chk("ml_sum", 32'(s4), 32'h6);
        chk("ml_cy",  32'(c4), 32'h8);
        @(posedge clk); #1;
        chk("ml_sum_q", 32'(s4_q), 32'h6);
        chk("ml_cy_q",  32'(c4_q), 32'h8);

        // random lanes against the arithmetic model
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            a4 = 4'($urandom);
            b4 = 4'($urandom);
            a1 = 1'($urandom);
            b1 = 1'($urandom);
            exp4 = ha_model(a4, b4);
            exp1 = ha_model({3'b0, a1}, {3'b0, b1});
            #1;
            chk("rnd_sum4", 32'(s4), 32'(exp4[3:0]));
            chk("rnd_cy4",  32'(c4), 32'(exp4[7:4]));
            chk("rnd_sc1",  32'({c1, s1}), 32'({exp1[4], exp1[0]}));
            @(posedge clk); #1;
            chk("rnd_sum4_q", 32'(s4_q), 32'(exp4[3:0]));
            chk("rnd_cy4_q",  32'(c4_q), 32'(exp4[7:4]));
            chk("rnd_sc1_q",  32'({c1_q, s1_q}), 32'({exp1[4], exp1[0]}));
        end

        // full-adder composition, all input combinations
        for (int k = 0; k < 8; k++) begin
            int t;
            @(negedge clk);
            ab = 4'(k);
            fa_a = ab[2]; fa_b = ab[1]; fa_cin = ab[0];
            t = k[2] + k[1] + k[0];
            #1;
            chk($sformatf("fa_sum_%0d", k),  32'(h2_s),    32'(t % 2));
            chk($sformatf("fa_cout_%0d", k), 32'(fa_cout), 32'(t / 2));
            @(posedge clk); #1;
            chk($sformatf("fa_sum_q_%0d", k), 32'({h1_sq, h1_cq, h2_sq, h2_cq}),
                32'({1'((k[2] + k[1]) % 2), 1'(k[2] & k[1]), 1'(t % 2),
                     1'(((k[2] + k[1]) % 2) & k[0])}));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // hard stop so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected completion");
        $fatal(1, "timeout");
    end

endmodule
